ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the EX-stage operands and the M-extension funct3, and computes the result over multiple cycles. While it computes, it holds `stall_md` high so the hazard logic freezes the PC, IF/ID and ID/EX registers. The result is presented for one cycle, during which the pipeline advances and the EX/MEM register captures it.

---
 rtl/ex_muldiv_unit_if.sv | 26 ++
 rtl/ex_muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Handshake/operand bundle between the EX stage and the iterative
// RV32M multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start_ex;
  logic [2:0]      md_op_ex;
  logic [XLEN-1:0] op1_ex;
  logic [XLEN-1:0] op2_ex;
  logic            flush_ex;
  logic            stall_md;
  logic [XLEN-1:0] result_md;
  logic            result_valid_md;

  // Pipeline side: issues the instruction, observes stall and result.
  modport master (
    output start_ex, md_op_ex, op1_ex, op2_ex, flush_ex,
    input  stall_md, result_md, result_valid_md
  );

  // Unit side.
  modport slave (
    input  start_ex, md_op_ex, op1_ex, op2_ex, flush_ex,
    output stall_md, result_md, result_valid_md
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Unsigned shift-add multiply and restoring divide on operand magnitudes,
// 32 steps each, with a final two's-complement sign fix. Divide-by-zero
// and signed overflow finish without iterating.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  ex_muldiv_unit_if.slave md
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  state_e            r_state;
  md_op_e            r_op;
  logic [4:0]        r_cnt;
  logic [2*XLEN-1:0] r_acc;    // product, or {remainder, quotient}
  logic [XLEN-1:0]   r_a;      // multiplicand / dividend (shifted out MSB first)
  logic [XLEN-1:0]   r_b;      // multiplier (shifted out LSB first) / divisor
  logic              r_neg;    // negate the final result
  logic [XLEN-1:0]   r_result;
  logic              r_valid;

  md_op_e            w_in_op;
  logic              w_op1_neg;
  logic              w_op2_neg;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_sign;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_shift;
  logic [XLEN:0]     w_trial;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_in_op = md_op_e'(md.md_op_ex);

  // Operand magnitudes, result sign and early-exit cases for the incoming op.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    w_op1_neg     = 1'b0;
    w_op2_neg     = 1'b0;
    w_special     = 1'b0;
    w_special_res = '0;
    if (w_in_op == OP_MULH || w_in_op == OP_MULHSU ||
        w_in_op == OP_DIV  || w_in_op == OP_REM)
      w_op1_neg = md.op1_ex[XLEN-1];
    if (w_in_op == OP_MULH || w_in_op == OP_DIV || w_in_op == OP_REM)
      w_op2_neg = md.op2_ex[XLEN-1];
    w_mag1 = w_op1_neg ? (~md.op1_ex + 1'b1) : md.op1_ex;
    w_mag2 = w_op2_neg ? (~md.op2_ex + 1'b1) : md.op2_ex;
    // Remainder takes the dividend's sign; products and quotients the XOR.
    w_sign = (w_in_op == OP_REM) ? w_op1_neg : (w_op1_neg ^ w_op2_neg);

    if (w_in_op[2] && md.op2_ex == '0) begin
      w_special     = 1'b1;
      w_special_res = w_in_op[1] ? md.op1_ex : ALL_ONE;
    end else if ((w_in_op == OP_DIV || w_in_op == OP_REM) &&
                 md.op1_ex == MIN_NEG && md.op2_ex == ALL_ONE) begin
      w_special     = 1'b1;
      w_special_res = w_in_op[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration step: shift-add multiply or restoring divide.
  always_comb begin
    w_sum       = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_b[0] ? r_a : '0)};
    w_rem_shift = {r_acc[2*XLEN-1:XLEN], r_a[XLEN-1]};
    w_trial     = w_rem_shift - {1'b0, r_b};
    w_acc_next  = r_acc;
    if (r_op[2]) begin
      if (!w_trial[XLEN])
        w_acc_next = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      else
        w_acc_next = {w_rem_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end else begin
      w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    end
  end

  // Sign fix and result selection applied to the last step's accumulator.
  always_comb begin
    w_prod  = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
    w_quo   = r_neg ? (~w_acc_next[XLEN-1:0] + 1'b1) : w_acc_next[XLEN-1:0];
    w_rem   = r_neg ? (~w_acc_next[2*XLEN-1:XLEN] + 1'b1)
                    : w_acc_next[2*XLEN-1:XLEN];
    w_final = '0;
    case (r_op)
      OP_MUL:                       w_final = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = w_quo;
      default:                      w_final = w_rem;
    endcase
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // pre-edge values regardless of statement order.
      r_valid <= 1'b0;
      if (md.flush_ex) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (md.start_ex) begin
              r_op  <= w_in_op;
              r_a   <= w_mag1;
              r_b   <= w_mag2;
              r_neg <= w_sign;
              r_acc <= '0;
              r_cnt <= '0;
              if (w_special) begin
                r_result <= w_special_res;
                r_valid  <= 1'b1;
                r_state  <= DONE;
              end else begin
                r_state <= COMPUTE;
              end
            end
          end
          COMPUTE: begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_op[2]) r_a <= {r_a[XLEN-2:0], 1'b0};
            else         r_b <= {1'b0, r_b[XLEN-1:1]};
            if (r_cnt == 5'd31) begin
              r_result <= w_final;
              r_valid  <= 1'b1;
              r_state  <= DONE;
            end
          end
          default: r_state <= IDLE;  // DONE: a held start_ex is not a new request
        endcase
      end
    end
  end

  assign md.stall_md        = md.start_ex & ~md.flush_ex & (r_state != DONE);
  assign md.result_md       = r_result;
  assign md.result_valid_md = r_valid;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: arithmetic results, latency, stall
// window, early-exit divides, flush, async reset and back-to-back issue.
module tb_ex_muldiv_unit;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;
  logic [31:0] last_res;

  ex_muldiv_unit_if #(.XLEN(32)) md_if ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op in IDLE and follow it to DONE. Cycle 0 is the first cycle
  // start_ex is high; operands are scrambled from cycle 1 on.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int vc;
    int st;
    vc = -1;
    st = 0;
    @(posedge clk); #1;
    md_if.md_op_ex = op;
    md_if.op1_ex   = a;
    md_if.op2_ex   = b;
    md_if.start_ex = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (md_if.stall_md) st++;
      if (md_if.result_valid_md) begin
        vc = c;
        break;
      end
      if (c == 0) begin
        @(posedge clk); #1;
        md_if.op1_ex = ~a;
        md_if.op2_ex = ~b;
      end
    end
    check({tag, "_lat"}, 32'(vc), 32'(lat));
    check({tag, "_stall"}, 32'(st), 32'(lat));
    check({tag, "_res"}, md_if.result_md, exp);
    @(posedge clk); #1;
    md_if.start_ex = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, md_if.result_valid_md}, 32'd0);
    last_res = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int vcnt;
    int v1;
    int v2;
    bit changed;
    n_checks = 0;
    n_errors = 0;
    last_res = '0;
    resetn          = 1'b0;
    md_if.start_ex  = 1'b0;
    md_if.md_op_ex  = 3'b000;
    md_if.op1_ex    = '0;
    md_if.op2_ex    = '0;
    md_if.flush_ex  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_res",   md_if.result_md, 32'd0);
    check("rst_valid", {31'd0, md_if.result_valid_md}, 32'd0);
    check("rst_stall", {31'd0, md_if.stall_md}, 32'd0);

    // Multiplies
    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mulh_n", 3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33);

    // Divides
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 33);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 33);
    run_op("divu",   3'b101, 32'd100,       32'd7,  32'd14,        33);
    run_op("remu",   3'b111, 32'd100,       32'd7,  32'd2,         33);
    run_op("div_nn", 3'b100, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);

    // Early-exit divides
    run_op("div0",   3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu0",  3'b111, 32'd5,         32'd0,         32'd5,         1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Flush a DIVU in cycle 10: no pulse, result unchanged.
    @(posedge clk); #1;
    md_if.md_op_ex = 3'b101;
    md_if.op1_ex   = 32'd100;
    md_if.op2_ex   = 32'd7;
    md_if.start_ex = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    md_if.flush_ex = 1'b1;
    @(negedge clk);
    check("flush_stall", {31'd0, md_if.stall_md}, 32'd0);
    @(posedge clk); #1;
    md_if.flush_ex = 1'b0;
    md_if.start_ex = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (md_if.result_valid_md) vcnt++;
    end
    check("flush_nopulse", 32'(vcnt), 32'd0);
    check("flush_res", md_if.result_md, last_res);

    // Flush together with start in IDLE: no start.
    @(posedge clk); #1;
    md_if.md_op_ex = 3'b100;
    md_if.op1_ex   = 32'd5;
    md_if.op2_ex   = 32'd0;
    md_if.start_ex = 1'b1;
    md_if.flush_ex = 1'b1;
    @(negedge clk);
    check("idleflush_stall", {31'd0, md_if.stall_md}, 32'd0);
    @(posedge clk); #1;
    md_if.start_ex = 1'b0;
    md_if.flush_ex = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (md_if.result_valid_md) vcnt++;
    end
    check("idleflush_nopulse", 32'(vcnt), 32'd0);

    // Async reset in cycle 5 of a MUL.
    @(posedge clk); #1;
    md_if.md_op_ex = 3'b000;
    md_if.op1_ex   = 32'd9;
    md_if.op2_ex   = 32'd9;
    md_if.start_ex = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("arst_res",   md_if.result_md, 32'd0);
    check("arst_valid", {31'd0, md_if.result_valid_md}, 32'd0);
    check("arst_stall", {31'd0, md_if.stall_md}, 32'd1);
    md_if.start_ex = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    run_op("mul_after_rst", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

    // Back-to-back DIVU with start_ex held throughout.
    @(posedge clk); #1;
    md_if.md_op_ex = 3'b101;
    md_if.op1_ex   = 32'd100;
    md_if.op2_ex   = 32'd7;
    md_if.start_ex = 1'b1;
    vcnt    = 0;
    v1      = -1;
    v2      = -1;
    changed = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (md_if.result_valid_md) begin
        vcnt++;
        if (vcnt == 1) begin
          v1 = c;
          check("b2b_res1", md_if.result_md, 32'd14);
        end else begin
          v2 = c;
          check("b2b_res2", md_if.result_md, 32'd100);
        end
      end
      @(posedge clk); #1;
      if (vcnt == 1 && !changed) begin
        md_if.op1_ex = 32'd1000;
        md_if.op2_ex = 32'd10;
        changed = 1'b1;
      end
      if (vcnt == 2) break;
    end
    md_if.start_ex = 1'b0;
    check("b2b_first_at", 32'(v1), 32'd33);
    check("b2b_gap", 32'(v2 - v1), 32'd34);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
